// File: rtl/conv3x3_multich_stride.sv
// conv3x3_multich_stride: CH-channel streaming 3x3 convolution, shared signed kernel, stride 1/2; define CONV_RELU_EN to clamp negative results to 0
module conv3x3_multich_stride #(
    parameter int CH     = 32,
    parameter int DATA_W = 32,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 9,
    parameter int OUT_W  = DATA_W + COEF_W + 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [CH*DATA_W-1:0]  pxl_in,
    input  logic [9*COEF_W-1:0]   coef_in,
    input  logic                  stride_sel,
    output logic [CH*OUT_W-1:0]   pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);
    localparam int PW  = DATA_W + COEF_W + 1;
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    // last qualifying row/col at stride 2: windows sit at even indices starting from 2
    localparam int LR2 = IMG_H - 1 - ((IMG_H - 3) % 2);
    localparam int LC2 = IMG_W - 1 - ((IMG_W - 3) % 2);

    logic [XW-1:0]            col;
    logic [YW-1:0]            row;
    logic [9*COEF_W-1:0]      coef_r;
    logic                     stride_r;
    logic [DATA_W-1:0]        lb0 [CH][IMG_W];
    logic [DATA_W-1:0]        lb1 [CH][IMG_W];
    logic [DATA_W-1:0]        win [CH][9];
    logic signed [PW-1:0]     prod_c [CH][9];
    logic signed [PW-1:0]     prod [CH][9];
    logic signed [OUT_W-1:0]  sum_c [CH];
    logic                     win_v, win_last, s1_v, s1_last, out_last;
    logic                     start, col_end, row_end, qual, last;

    assign start   = valid_in && col == '0 && row == '0;
    assign col_end = col == XW'(IMG_W - 1);
    assign row_end = row == YW'(IMG_H - 1);
    assign qual    = row >= YW'(2) && col >= XW'(2) && (!stride_r || (!row[0] && !col[0]));
    assign last    = stride_r ? (row == YW'(LR2) && col == XW'(LC2)) : (row_end && col_end);

    // per-tap signed products; pixel zero-extended so it is never read as negative
    always_comb begin
        for (int k = 0; k < CH; k++)
            for (int t = 0; t < 9; t++)
                prod_c[k][t] = PW'($signed({1'b0, win[k][t]})) * PW'($signed(coef_r[t*COEF_W +: COEF_W]));
    end

    // adder tree over the registered products, sign-extended to the full output width
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            sum_c[k] = '0;
            for (int t = 0; t < 9; t++)
                sum_c[k] = sum_c[k] + OUT_W'(prod[k][t]);
        end
    end

    // datapath storage: kernel/stride shadows, line buffers, windows, stage-1 products (never reset)
    always_ff @(posedge clk) begin
        if (start) begin
            coef_r   <= coef_in;
            stride_r <= stride_sel;
        end
        if (valid_in) begin
            for (int k = 0; k < CH; k++) begin
                for (int r = 0; r < 3; r++) begin
                    win[k][r*3]   <= win[k][r*3+1];
                    win[k][r*3+1] <= win[k][r*3+2];
                end
                win[k][2]      <= lb1[k][col];
                win[k][5]      <= lb0[k][col];
                win[k][8]      <= pxl_in[k*DATA_W +: DATA_W];
                lb0[k][col]    <= pxl_in[k*DATA_W +: DATA_W];
                lb1[k][col]    <= lb0[k][col];
            end
        end
        if (win_v) begin
            for (int k = 0; k < CH; k++)
                for (int t = 0; t < 9; t++)
                    prod[k][t] <= prod_c[k][t];
        end
    end

    // raster counters, pipeline valid/last flags and the stage-2 output register
    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            win_v      <= 1'b0;
            win_last   <= 1'b0;
            s1_v       <= 1'b0;
            s1_last    <= 1'b0;
            valid_out  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            pxl_out    <= '0;
        end else begin
            win_v      <= valid_in && qual;
            win_last   <= valid_in && qual && last;
            s1_v       <= win_v;
            s1_last    <= win_last;
            valid_out  <= s1_v;
            out_last   <= s1_last;
            frame_done <= out_last;
            if (valid_in) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row_end ? '0 : row + 1'b1;
            end
            if (s1_v) begin
                for (int k = 0; k < CH; k++)
`ifdef CONV_RELU_EN
                    pxl_out[k*OUT_W +: OUT_W] <= sum_c[k][OUT_W-1] ? '0 : sum_c[k];
`else
                    pxl_out[k*OUT_W +: OUT_W] <= sum_c[k];
`endif
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_multich_stride.sv
// tb_conv3x3_multich_stride: directed self-checking bench for conv3x3_multich_stride
module tb_conv3x3_multich_stride;
    localparam int CH = 32, DW = 32, CW = 8, W = 9, H = 9, OW = DW + CW + 4;

    logic               clk = 1'b0, reset = 1'b1, valid_in = 1'b0, stride_sel = 1'b0;
    logic [CH*DW-1:0]   pxl_in = '0;
    logic [9*CW-1:0]    coef_in = '0;
    logic [CH*OW-1:0]   pxl_out;
    logic               valid_out, frame_done;

    int                 n_chk = 0, n_fail = 0, cyc = 0, acc20 = 0;
    int                 cf [9];
    logic [CH*OW-1:0]   oq [$];
    int                 ocyc [$];
    int                 dq [$];
    logic signed [OW-1:0] got, e;

    conv3x3_multich_stride dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .coef_in(coef_in), .stride_sel(stride_sel), .pxl_out(pxl_out),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            oq.push_back(pxl_out);
            ocyc.push_back(cyc);
        end
        if (frame_done) dq.push_back(cyc);
    end

    function automatic longint pix(int mode, int cval, int k, int r, int c);
        return mode == 0 ? longint'(cval) : longint'(k*100 + r*W + c);
    endfunction

    function automatic longint expv(int mode, int cval, int k, int r, int c);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(cf[i*3+j]) * pix(mode, cval, k, r-2+i, c-2+j);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic int wr(int s, int n);
        return 2 + (s ? 2 : 1) * (n / (s ? (W-1)/2 : W-2));
    endfunction

    function automatic int wc(int s, int n);
        return 2 + (s ? 2 : 1) * (n % (s ? (W-1)/2 : W-2));
    endfunction

    task automatic set_coef();
        for (int t = 0; t < 9; t++) coef_in[t*CW +: CW] = CW'(cf[t]);
    endtask

    task automatic clr();
        oq.delete(); ocyc.delete(); dq.delete();
    endtask

    task automatic drive_px(input int mode, input int cval, input int r, input int c, input bit gaps);
        if (gaps)
            for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
        for (int k = 0; k < CH; k++) pxl_in[k*DW +: DW] = DW'(pix(mode, cval, k, r, c));
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int cval, input bit gaps, input bit fc, input bit fs);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                drive_px(mode, cval, r, c, gaps);
                if (r*W + c == 20) acc20 = cyc;
                if (r == 0 && c == 0) begin
                    if (fc) begin
                        for (int t = 0; t < 9; t++) cf[t] = -cf[t];
                        set_coef();
                    end
                    if (fs) stride_sel = !stride_sel;
                end
            end
    endtask

    task automatic drain();
        valid_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", valid_out); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", frame_done); end
        n_chk++; if (pxl_out !== '0) begin n_fail++; $display("FAIL reset_pxl got nonzero expected 0"); end
        reset = 1'b0;
        clr();
    endtask

    task automatic test_ones_s1();
        for (int t = 0; t < 9; t++) cf[t] = 1;
        set_coef();
        stride_sel = 1'b0;
        clr();
        send_frame(0, 1, 0, 0, 0);
        drain();
        n_chk++; if (oq.size() !== 49) begin n_fail++; $display("FAIL ones_count got %0d expected 49", oq.size()); end
        for (int n = 0; n < oq.size() && n < 49; n++)
            for (int k = 0; k < CH; k++) begin
                got = oq[n][k*OW +: OW];
                e = OW'(expv(0, 1, k, wr(0, n), wc(0, n)));
                n_chk++; if (got !== e) begin n_fail++; $display("FAIL ones_val n=%0d ch=%0d got %0d expected %0d", n, k, got, e); end
            end
        if (oq.size() > 0) begin
            n_chk++; if (ocyc[0] !== acc20 + 2) begin n_fail++; $display("FAIL ones_latency got cycle %0d expected %0d", ocyc[0], acc20 + 2); end
        end
        n_chk++; if (dq.size() !== 1) begin n_fail++; $display("FAIL ones_done_count got %0d expected 1", dq.size()); end
        if (dq.size() > 0 && oq.size() > 0) begin
            n_chk++; if (dq[0] !== ocyc[ocyc.size()-1] + 1) begin n_fail++; $display("FAIL ones_done_time got %0d expected %0d", dq[0], ocyc[ocyc.size()-1] + 1); end
        end
    endtask

    task automatic test_ramp_center(input bit gaps);
        for (int t = 0; t < 9; t++) cf[t] = (t == 4) ? 1 : 0;
        set_coef();
        stride_sel = 1'b0;
        clr();
        send_frame(1, 0, gaps, 0, 0);
        drain();
        n_chk++; if (oq.size() !== 49) begin n_fail++; $display("FAIL ramp_count gaps=%0d got %0d expected 49", gaps, oq.size()); end
        for (int n = 0; n < oq.size() && n < 49; n++)
            for (int k = 0; k < CH; k++) begin
                got = oq[n][k*OW +: OW];
                e = OW'(expv(1, 0, k, wr(0, n), wc(0, n)));
                n_chk++; if (got !== e) begin n_fail++; $display("FAIL ramp_val gaps=%0d n=%0d ch=%0d got %0d expected %0d", gaps, n, k, got, e); end
            end
        n_chk++; if (dq.size() !== 1) begin n_fail++; $display("FAIL ramp_done_count gaps=%0d got %0d expected 1", gaps, dq.size()); end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 9; t++) cf[t] = (t == 4) ? 1 : 0;
        set_coef();
        stride_sel = 1'b0;
        clr();
        send_frame(1, 0, 0, 0, 1);
        send_frame(1, 0, 0, 0, 0);
        drain();
        n_chk++; if (oq.size() !== 65) begin n_fail++; $display("FAIL b2b_count got %0d expected 65", oq.size()); end
        for (int n = 0; n < oq.size() && n < 65; n++)
            for (int k = 0; k < CH; k++) begin
                got = oq[n][k*OW +: OW];
                e = (n < 49) ? OW'(expv(1, 0, k, wr(0, n), wc(0, n))) : OW'(expv(1, 0, k, wr(1, n-49), wc(1, n-49)));
                n_chk++; if (got !== e) begin n_fail++; $display("FAIL b2b_val n=%0d ch=%0d got %0d expected %0d", n, k, got, e); end
            end
        n_chk++; if (dq.size() !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d expected 2", dq.size()); end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 9; t++) cf[t] = (t == 4) ? 1 : 0;
        set_coef();
        stride_sel = 1'b0;
        for (int i = 0; i < 40; i++) drive_px(1, 0, i / W, i % W, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        clr();
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL midreset_flush got %b expected 0", valid_out); end
        reset = 1'b0;
        send_frame(1, 0, 0, 0, 0);
        drain();
        n_chk++; if (oq.size() !== 49) begin n_fail++; $display("FAIL midreset_count got %0d expected 49", oq.size()); end
        for (int n = 0; n < oq.size() && n < 49; n++)
            for (int k = 0; k < CH; k++) begin
                got = oq[n][k*OW +: OW];
                e = OW'(expv(1, 0, k, wr(0, n), wc(0, n)));
                n_chk++; if (got !== e) begin n_fail++; $display("FAIL midreset_val n=%0d ch=%0d got %0d expected %0d", n, k, got, e); end
            end
        n_chk++; if (dq.size() !== 1) begin n_fail++; $display("FAIL midreset_done_count got %0d expected 1", dq.size()); end
    endtask

    task automatic test_coef_shadow();
        for (int t = 0; t < 9; t++) cf[t] = -1;
        set_coef();
        stride_sel = 1'b0;
        clr();
        send_frame(0, 5, 0, 1, 0);
        drain();
        for (int t = 0; t < 9; t++) cf[t] = -1;
        n_chk++; if (oq.size() !== 49) begin n_fail++; $display("FAIL neg_count got %0d expected 49", oq.size()); end
        for (int n = 0; n < oq.size() && n < 49; n++)
            for (int k = 0; k < CH; k++) begin
                got = oq[n][k*OW +: OW];
                e = OW'(expv(0, 5, k, wr(0, n), wc(0, n)));
                n_chk++; if (got !== e) begin n_fail++; $display("FAIL neg_val n=%0d ch=%0d got %0d expected %0d", n, k, got, e); end
            end
        for (int t = 0; t < 9; t++) cf[t] = 1;
        clr();
        send_frame(0, 5, 0, 0, 0);
        drain();
        n_chk++; if (oq.size() !== 49) begin n_fail++; $display("FAIL pos_count got %0d expected 49", oq.size()); end
        for (int n = 0; n < oq.size() && n < 49; n++)
            for (int k = 0; k < CH; k++) begin
                got = oq[n][k*OW +: OW];
                e = OW'(expv(0, 5, k, wr(0, n), wc(0, n)));
                n_chk++; if (got !== e) begin n_fail++; $display("FAIL pos_val n=%0d ch=%0d got %0d expected %0d", n, k, got, e); end
            end
    endtask

    initial begin
        test_reset();
        test_ones_s1();
        test_ramp_center(0);
        test_ramp_center(1);
        test_back_to_back();
        test_reset_mid();
        test_coef_shadow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv3x3_multich_stride.md
Name: conv3x3_multich_stride

Overview:
- Parametrised successor to the fixed 32-lane, 3x3 stride-1 convolution block.
- Streams CH channels of a raster-ordered IMG_W x IMG_H image on one shared valid qualifier.
- Builds a 3x3 window per channel from two line buffers and applies one shared, runtime-loadable signed 3x3 kernel to every channel.
- Stride (1 or 2) is selectable per frame. Sits between the pixel source and the downstream pooling/activation stage.

Parameters:
- CH, 32, number of parallel channels.
- DATA_W, 32, unsigned pixel width per channel.
- COEF_W, 8, signed kernel coefficient width.
- IMG_W, 9, image width in pixels (>= 3).
- IMG_H, 9, image height in rows (>= 3).
- OUT_W, DATA_W+COEF_W+4, signed result width per channel (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  qualifies pxl_in for all channels this cycle.
- pxl_in  in  CH*DATA_W  packed pixels; channel k occupies bits [k*DATA_W +: DATA_W].
- coef_in  in  9*COEF_W  kernel; tap r*3+c (r = row, c = col, 0 = top-left) occupies bits [(r*3+c)*COEF_W +: COEF_W].
- stride_sel  in  1  0 = stride 1, 1 = stride 2.
- pxl_out  out  CH*OUT_W  packed signed results; channel k occupies bits [k*OUT_W +: OUT_W].
- valid_out  out  1  pxl_out holds a valid window result.
- frame_done  out  1  one-cycle pulse after the last output of a frame.

Behaviour:
- Reset (synchronous, active-high): col/row counters = 0; valid_out = 0; pxl_out = 0; frame_done = 0; pipeline valid flags = 0. Line-buffer and window contents are not cleared; outputs gate them by counter position.
- Frame start is an accepted pixel (valid_in = 1) with col = 0 and row = 0. At that beat, latch coef_in and stride_sel into shadow registers. Mid-frame changes on those inputs are ignored.
- Every accepted pixel:
  - shifts each channel's 3x3 window left by one column;
  - loads the new right column from {line buffer 1, line buffer 0, pxl_in};
  - writes pxl_in to line buffer 0 and line buffer 0's output to line buffer 1 at index col;
  - increments col. At col = IMG_W-1, col wraps to 0 and row increments. At row = IMG_H-1 with col = IMG_W-1, both wrap to 0.
- valid_in = 0: window, line buffers and counters hold. Pipeline stages keep advancing.
- Window-valid condition, evaluated on the accepted pixel: row >= 2, col >= 2, ((row-2) mod S) == 0 and ((col-2) mod S) == 0, where S = 1 or 2. No padding; the window does not wrap across row edges.
- Pipeline, 2 cycles fixed:
  - Stage 1 registers the 9 signed products per channel (pixel zero-extended to DATA_W+1 bits).
  - Stage 2 registers the sign-extended sum in OUT_W bits, so no overflow is possible.
  - valid_out asserts exactly 2 cycles after the accepted bottom-right pixel of a qualifying window.
- Output counts per frame: (IMG_H-2)*(IMG_W-2) for stride 1, ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2) for stride 2.
- valid_out = 0: pxl_out holds its last value.
- frame_done pulses on the cycle after valid_out for the last qualifying window of the frame.
- Back-to-back frames need no idle cycles. Stage-1/2 results of the previous frame still complete after the next frame's first pixel is accepted.
- Reset mid-frame: the in-flight pipeline is flushed (valid_out = 0 on the next cycle) and the counters restart. The next accepted pixel is the top-left of a new frame.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: stage 2 writes 0 for any negative sum, so pxl_out is never negative.
- Undefined: the full signed sum is output.
- Latency, valid_out timing and frame_done timing are identical either way.

Test Plan:
- Defaults (9x9, CH = 32), all pixels 1, all coefs 1, stride 1, continuous valid_in -> 49 valid_out pulses, every channel = 9, first valid_out 2 cycles after pixel index 20, frame_done after the 49th.
- Same image, stride_sel = 1 -> 16 valid_out pulses, all channels = 9; outputs centred at rows/cols 1, 3, 5, 7.
- Channel k pixel = k*100 + row*9 + col, centre coef only = 1 -> each output equals that channel's window-centre pixel; channels are independent.
- Random valid_in gaps (about 50% duty) with the ramp image -> same output values and order as the continuous run, 49 results.
- Assert reset after 40 pixels, then send a full frame -> no stale valid_out; exactly 49 correct results.
- All coefs = -1, all pixels 5 -> results -45 without CONV_RELU_EN and 0 with it. Changing coef_in mid-frame has no effect until the next frame start.
